// File: rtl/reset_sequencer_if.sv
// Reset sequencer interface: lock/ready inputs and per-stage reset/status outputs.
interface reset_sequencer_if #(
    parameter int unsigned NUM_STAGES = 4
);
    logic                  locked_i;
    logic [NUM_STAGES-1:0] stage_ready_i;
    logic [NUM_STAGES-1:0] reset_o;
    logic                  all_ready_o;
    logic                  timeout_o;
    logic [2:0]            fault_stage_o;

    // Controller side: drives lock and stage readiness, observes the sequencer.
    modport master (
        output locked_i, stage_ready_i,
        input  reset_o, all_ready_o, timeout_o, fault_stage_o
    );

    // Sequencer side.
    modport slave (
        input  locked_i, stage_ready_i,
        output reset_o, all_ready_o, timeout_o, fault_stage_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES subsystem resets one at a time once the PLL is locked, waiting for each
// stage to report ready before releasing the next. Lock loss re-asserts every reset; a stage
// that never acknowledges parks the block in a sticky fault until reset_i.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES  = 4,
    parameter int unsigned STAGE_DELAY = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic              clk_i,
    input logic              reset_i,
    reset_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StDelay, StWaitAck, StDone, StFault} state_e;

    localparam logic [7:0] DelayLast   = 8'(STAGE_DELAY - 1);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);
    localparam logic [2:0] LastStage   = 3'(NUM_STAGES - 1);

    state_e                state_q, state_d;
    logic [2:0]            stage_q, stage_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] reset_q, reset_d;
    logic                  all_ready_q, all_ready_d;
    logic                  timeout_q, timeout_d;
    logic [2:0]            fault_stage_q, fault_stage_d;
    logic                  ready_sel;
    logic                  lock_lost;

    // Pick out the ready bit of the stage currently being waited on; all others are ignored.
    always_comb begin
        ready_sel = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (stage_q == 3'(k)) begin
                ready_sel = bus.stage_ready_i[k];
            end
        end
    end

    // FAULT and IDLE ignore the lock; everywhere else losing it restarts the sequence.
    assign lock_lost = !bus.locked_i &&
                       (state_q == StDelay || state_q == StWaitAck || state_q == StDone);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        stage_d       = stage_q;
        cnt_d         = cnt_q;
        reset_d       = reset_q;
        all_ready_d   = all_ready_q;
        timeout_d     = timeout_q;
        fault_stage_d = fault_stage_q;

        if (lock_lost) begin
            state_d     = StIdle;
            stage_d     = '0;
            cnt_d       = '0;
            reset_d     = '1;
            all_ready_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.locked_i) begin
                        state_d = StDelay;
                        cnt_d   = '0;
                    end
                end
                StDelay: begin
                    if (cnt_q == DelayLast) begin
                        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                            if (stage_q == 3'(k)) begin
                                reset_d[k] = 1'b0;
                            end
                        end
                        state_d = StWaitAck;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StWaitAck: begin
                    // A ready on the final timeout edge still wins over the fault.
                    if (ready_sel) begin
                        cnt_d = '0;
                        if (stage_q == LastStage) begin
                            state_d     = StDone;
                            all_ready_d = 1'b1;
                        end else begin
                            state_d = StDelay;
                            stage_d = stage_q + 3'd1;
                        end
                    end else if (cnt_q == TimeoutLast) begin
                        state_d       = StFault;
                        timeout_d     = 1'b1;
                        fault_stage_d = stage_q;
                        reset_d       = '1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StDone:  ;
                StFault: ;
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            stage_q       <= '0;
            cnt_q         <= '0;
            reset_q       <= '1;
            all_ready_q   <= 1'b0;
            timeout_q     <= 1'b0;
            fault_stage_q <= '0;
        end else begin
            state_q       <= state_d;
            stage_q       <= stage_d;
            cnt_q         <= cnt_d;
            reset_q       <= reset_d;
            all_ready_q   <= all_ready_d;
            timeout_q     <= timeout_d;
            fault_stage_q <= fault_stage_d;
        end
    end

    assign bus.reset_o       = reset_q;
    assign bus.all_ready_o   = all_ready_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.fault_stage_o = fault_stage_q;

endmodule
